lbm_frame_sched: RTL
====================

LBM_FRAME_SCHED -- requirements
Module: lbm_frame_sched

Interface
REQ-001 Parameter DEPTH, default 2500, number of lattice sites (BRAM words) per sweep.
REQ-002 Parameter ADDRESS_WIDTH, default 12, width of bram_addr; 2^ADDRESS_WIDTH SHALL be at least DEPTH.
REQ-003 aclk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 areset  input  1  reset: synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-006 run  input  1  continuous mode; sampled in FRAME_END.
REQ-007 abort  input  1  cancels the current frame.
REQ-008 steps_per_frame  input  8  number of compute sweeps per frame; sampled on an accepted start.
REQ-009 cmp_ready  input  1  compute engine accepts the current address.
REQ-010 cmp_done  input  1  one-cycle pulse: compute pipeline has drained the sweep.
REQ-011 rdo_ready  input  1  AXI-Stream readout path accepts the current address.
REQ-012 bram_addr  output  ADDRESS_WIDTH  shared BRAM read address.
REQ-013 addr_valid  output  1  bram_addr is valid for the selected consumer.
REQ-014 sel_rdo  output  1  0 = compute owns the port, 1 = readout owns the port.
REQ-015 addr_last  output  1  high with addr_valid when bram_addr == DEPTH-1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 frame_done  output  1  one-cycle pulse at frame completion.
REQ-018 frame_cnt  output  16  count of completed frames.

Function
REQ-019 All outputs SHALL be registered; addr_last SHALL derive from registered state and address only.
REQ-020 FSM states SHALL be IDLE, COMPUTE, CMP_WAIT, READOUT and FRAME_END.
REQ-021 IDLE, start=1: latch steps_per_frame into steps_q, clear step_cnt and bram_addr, next state COMPUTE; if steps_per_frame==0, next state READOUT instead.
REQ-022 COMPUTE: addr_valid=1, sel_rdo=0.
  - Handshake: addr_valid & cmp_ready.
  - On handshake with bram_addr < DEPTH-1: bram_addr increments by 1.
  - On handshake with bram_addr == DEPTH-1: bram_addr goes to 0, next state CMP_WAIT.
REQ-023 CMP_WAIT: addr_valid=0.
  - On cmp_done: step_cnt increments.
  - If step_cnt+1 == steps_q: next state READOUT; otherwise next state COMPUTE.
REQ-024 cmp_done SHALL be ignored in every state except CMP_WAIT, including the cycle of the final COMPUTE handshake.
REQ-025 READOUT: addr_valid=1, sel_rdo=1.
  - Handshake: addr_valid & rdo_ready; address advance as in COMPUTE.
  - Final handshake: bram_addr goes to 0, next state FRAME_END.
REQ-026 When the selected ready is low, bram_addr, addr_valid and sel_rdo SHALL hold; cmp_ready is ignored in READOUT and rdo_ready is ignored in COMPUTE.
REQ-027 FRAME_END (one cycle):
  - frame_done=1 and frame_cnt increments, wrapping 0xFFFF to 0.
  - run=1: clear step_cnt, next state COMPUTE (READOUT if steps_q==0), steps_q retained.
  - run=0: next state IDLE.
REQ-028 sel_rdo SHALL change only while addr_valid=0 or on a state transition; no address SHALL be presented to both consumers.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle with bram_addr=0, addr_valid=0, step_cnt=0, and no frame_done; frame_cnt holds.
REQ-030 abort SHALL take priority over start, handshakes and cmp_done in the same cycle.
REQ-031 start outside IDLE SHALL be ignored; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-032 Latency: addr_valid SHALL rise exactly 1 cycle after an accepted start.
REQ-033 A full frame with continuously asserted readies SHALL take steps_q*DEPTH + (cycles spent in CMP_WAIT) + DEPTH + 2 cycles from start to frame_done.

Reset
REQ-034 areset=1 at a clock edge SHALL set state IDLE, bram_addr=0, addr_valid=0, sel_rdo=0, addr_last=0, busy=0, frame_done=0, frame_cnt=0, steps_q=0, step_cnt=0.
REQ-035 areset SHALL override every input, including mid-sweep, and no output pulse SHALL follow it.

Verification
REQ-036 Test: DEPTH=4, steps_per_frame=2, readies tied 1, cmp_done 3 cycles after each CMP_WAIT entry -> address sequence 0-3 (sel 0), 0-3 (sel 0), 0-3 (sel 1); addr_last on each 3; one frame_done; frame_cnt=1.
REQ-037 Test: cmp_ready toggled 1/0 every cycle in COMPUTE -> bram_addr advances only on ready cycles; no address skipped or repeated.
REQ-038 Test: steps_per_frame=0 -> READOUT immediately, sel_rdo=1 from the first valid; cmp_done pulses ignored.
REQ-039 Test: abort at bram_addr=2 in READOUT -> IDLE next cycle, addr_valid=0, no frame_done, frame_cnt unchanged; a subsequent start runs a full frame.
REQ-040 Test: run=1 held for 3 frames with frame_cnt preset by running 65534 frames (or a forced value) -> frame_done 3 times and frame_cnt wraps to 1.
REQ-041 Test: areset asserted mid-COMPUTE, start asserted in the same cycle -> all outputs at reset values the next cycle; start has no effect.

Source files
------------

// File: rtl/lbm_frame_sched.sv
// lbm_frame_sched: owns the shared lattice BRAM read port and walks it through
// steps_per_frame compute sweeps followed by one readout sweep per frame.
module lbm_frame_sched #(
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic                     run,
    input  logic                     abort,
    input  logic [7:0]               steps_per_frame,
    input  logic                     cmp_ready,
    input  logic                     cmp_done,
    input  logic                     rdo_ready,
    output logic [ADDRESS_WIDTH-1:0] bram_addr,
    output logic                     addr_valid,
    output logic                     sel_rdo,
    output logic                     addr_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_cnt,
    output logic [2:0]               dbg_state
);
    // Handshake: a word transfers on a rising edge where addr_valid and the
    // ready of the consumer picked by sel_rdo are both high; otherwise
    // bram_addr, addr_valid and sel_rdo hold.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPUTE   = 3'd1,
        S_CMP_WAIT  = 3'd2,
        S_READOUT   = 3'd3,
        S_FRAME_END = 3'd4
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                 steps_q, steps_d;
    logic [7:0]                 step_cnt_q, step_cnt_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic                       addr_valid_q, addr_valid_d;
    logic                       sel_rdo_q, sel_rdo_d;
    logic                       busy_q, busy_d;
    logic                       frame_done_q, frame_done_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        steps_d     = steps_q;
        step_cnt_d  = step_cnt_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    steps_d    = steps_per_frame;
                    step_cnt_d = 8'd0;
                    addr_d     = '0;
                    state_d    = (steps_per_frame == 8'd0) ? S_READOUT : S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (cmp_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_CMP_WAIT;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_CMP_WAIT: begin
                if (cmp_done) begin
                    step_cnt_d = step_cnt_q + 8'd1;
                    state_d    = (step_cnt_q + 8'd1 == steps_q) ? S_READOUT : S_COMPUTE;
                end
            end
            S_READOUT: begin
                if (rdo_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d      = '0;
                        state_d     = S_FRAME_END;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_FRAME_END: begin
                if (run) begin
                    step_cnt_d = 8'd0;
                    state_d    = (steps_q == 8'd0) ? S_READOUT : S_COMPUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything else that happened this cycle.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            addr_d      = '0;
            step_cnt_d  = 8'd0;
            frame_cnt_d = frame_cnt_q;
        end

        addr_valid_d = (state_d == S_COMPUTE) || (state_d == S_READOUT);
        sel_rdo_d    = (state_d == S_READOUT);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_FRAME_END);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            steps_q      <= 8'd0;
            step_cnt_q   <= 8'd0;
            frame_cnt_q  <= 16'd0;
            addr_valid_q <= 1'b0;
            sel_rdo_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            steps_q      <= steps_d;
            step_cnt_q   <= step_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            addr_valid_q <= addr_valid_d;
            sel_rdo_q    <= sel_rdo_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bram_addr  = addr_q;
    assign addr_valid = addr_valid_q;
    assign sel_rdo    = sel_rdo_q;
    assign addr_last  = addr_valid_q && (addr_q == LAST_ADDR);
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign dbg_state  = state_q;

endmodule
